rdm_mem_arbiter: RTL and testbench
==================================

// Module: rdm_mem_arbiter
// PURPOSE
//  Shares the single DDR4 controller command/data port between NUM_REQ requesters
//  (req 0 = PCIe host DMA path, others = on-chip RDM engines).
//  Round-robin grant per command. A write grant is held until its burst is done.
//  Read responses come back in order and are steered to the issuing requester
//  through an in-order ID FIFO. Nothing is issued before DRAM calibration completes.
// PARAMETERS
//  NUM_REQ     2    number of requesters (2..8)
//  ADDR_W      32   byte address width
//  DATA_W      512  data beat width
//  LEN_W       8    burst length field; value = beats-1
//  RID_DEPTH   8    outstanding-read ID FIFO depth (power of 2)
// PORTS
//  clk          in   1               single clock for all logic
//  rst          in   1               asynchronous, active-high reset
//  calib_done   in   1               DDR4 calibration complete; arbitration gated on it
//  req_valid    in   NUM_REQ         per-requester command valid
//  req_ready    out  NUM_REQ         per-requester command accept
//  req_write    in   NUM_REQ         1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_W  packed command addresses
//  req_len      in   NUM_REQ*LEN_W   packed burst lengths (beats-1)
//  wr_valid     in   NUM_REQ         write data valid
//  wr_ready     out  NUM_REQ         write data accept
//  wr_data      in   NUM_REQ*DATA_W  packed write data
//  rd_valid     out  NUM_REQ         read data valid (one-hot or zero)
//  rd_ready     in   NUM_REQ         read data accept
//  rd_data      out  DATA_W          shared read data bus
//  rd_last      out  1               last beat of read burst
//  mc_cmd_valid out  1 / mc_cmd_ready in 1 / mc_cmd_write out 1
//  mc_cmd_addr  out  ADDR_W / mc_cmd_len out LEN_W            command to MC
//  mc_wr_valid  out  1 / mc_wr_ready in 1 / mc_wr_data out DATA_W / mc_wr_last out 1
//  mc_rd_valid  in   1 / mc_rd_ready out 1 / mc_rd_data in DATA_W / mc_rd_last in 1
//  grant_id     out  clog2(NUM_REQ)  current/last granted requester
//  busy         out  1               FSM not IDLE or ID FIFO non-empty
//  err          out  1               sticky: read beat with empty ID FIFO
// BEHAVIOUR
//  Reset (async assert, sync deassert use): FSM=IDLE; all valid/ready outputs 0.
//   err=0, grant_id=0, ID FIFO empty, rr pointer=NUM_REQ-1 (so req 0 wins first).
//  FSM IDLE->CMD->(IDLE | WDATA).
//  IDLE: if calib_done and any req_valid, grant the first valid index after the
//   rr pointer (modulo NUM_REQ) and register it into grant_id. Next cycle -> CMD.
//   Latency: req_valid at cycle 0 gives mc_cmd_valid at cycle 1.
//  CMD: mc_cmd_* = fields of the granted requester; req_ready[g]=mc_cmd_ready.
//   Read: mc_cmd_valid is held 0 while the ID FIFO is full. On handshake, push g,
//   set rr pointer=g, go IDLE.
//   Write: on handshake, load beat counter=req_len[g], set rr pointer=g, go WDATA.
//   requester must keep command stable while valid (AXI-style).
//  WDATA: mc_wr_valid=wr_valid[g], wr_ready[g]=mc_wr_ready, mc_wr_data=wr_data[g].
//   mc_wr_last=(counter==0). Each handshake decrements the counter.
//   Handshake with counter==0 -> IDLE.
//  Non-granted requesters see req_ready=0, wr_ready=0.
//  calib_done dropping does not abort a command in flight. It only blocks new grants.
//  Read return (independent of FSM, concurrent with writes): head = FIFO front.
//   rd_valid[head]=mc_rd_valid & !empty; mc_rd_ready=rd_ready[head] & !empty.
//   rd_data/rd_last pass through combinationally. Pop on handshake with mc_rd_last.
//   Push and pop in the same cycle leave the count unchanged.
//   FIFO pointers wrap mod RID_DEPTH; full = count==RID_DEPTH.
//  mc_rd_valid while FIFO empty: mc_rd_ready=0, err<=1 (sticky until rst).
//  Single-cycle grant decision. One command per CMD visit, so the minimum is 2 cycles/command.
// TESTING
//  1. rst high, calib_done=0, req_valid=2'b11 -> no mc_cmd_valid for 100 cycles; all outputs 0.
//  2. calib_done=1, both requesters issue reads back-to-back -> grants alternate 0,1,0,1.
//     First mc_cmd_valid 1 cycle after req_valid.
//  3. req0 write len=3 while req1 reads -> exactly 4 mc_wr beats from req0.
//     mc_wr_last on the 4th beat; req1 cmd issued only after that.
//  4. 8 reads issued, mc_rd held off -> 9th read blocked (mc_cmd_valid=0).
//     Returns (len=1 each) route to issuers in order; FIFO drains and busy=0.
//  5. mc_rd_valid with no outstanding read -> mc_rd_ready=0, err=1 and stays 1.
//  6. rst asserted mid-WDATA (2 of 4 beats sent) -> same cycle: outputs 0, FIFO empty.
//     After release, req0 granted first.

Source files
------------

// File: rtl/rdm_mem_arbiter.sv
// rdm_mem_arbiter: shares one DDR4 controller port between NUM_REQ requesters.
// Round-robin grant per command, write grant held for the whole burst, and
// in-order read return steered through an outstanding-read ID FIFO.
module rdm_mem_arbiter #(
  parameter  int NUM_REQ   = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 512,
  parameter  int LEN_W     = 8,
  parameter  int RID_DEPTH = 8,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW        = (RID_DEPTH > 1) ? $clog2(RID_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      calib_done,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        wr_valid,
  output logic [NUM_REQ-1:0]        wr_ready,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ-1:0]        rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic                      mc_cmd_valid,
  input  logic                      mc_cmd_ready,
  output logic                      mc_cmd_write,
  output logic [ADDR_W-1:0]         mc_cmd_addr,
  output logic [LEN_W-1:0]          mc_cmd_len,
  output logic                      mc_wr_valid,
  input  logic                      mc_wr_ready,
  output logic [DATA_W-1:0]         mc_wr_data,
  output logic                      mc_wr_last,
  input  logic                      mc_rd_valid,
  output logic                      mc_rd_ready,
  input  logic [DATA_W-1:0]         mc_rd_data,
  input  logic                      mc_rd_last,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_q, nxt_gnt;
  logic              gnt_found;
  logic [LEN_W-1:0]  beat_q;
  logic [GW-1:0]     rid_mem [RID_DEPTH];
  logic [PW-1:0]     rid_wp, rid_rp;
  logic [PW:0]       rid_cnt;
  logic              rid_full, rid_empty, push, pop;
  logic              cmd_hs, wr_hs, cmd_is_wr, cmd_blk;
  logic [GW-1:0]     head;

  // per-requester views of the packed command/data buses
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [LEN_W-1:0]  len_a  [NUM_REQ];
  logic [DATA_W-1:0] wdat_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = req_len[i*LEN_W +: LEN_W];
    assign wdat_a[i] = wr_data[i*DATA_W +: DATA_W];
  end

  assign rid_full  = (rid_cnt == (PW+1)'(RID_DEPTH));
  assign rid_empty = (rid_cnt == '0);
  assign cmd_is_wr = req_write[grant_id];
  // a read command may not go out when there is no room to record its ID
  assign cmd_blk   = !cmd_is_wr && rid_full;
  assign cmd_hs    = (state_q == CMD) && mc_cmd_valid && mc_cmd_ready;
  assign wr_hs     = (state_q == WDATA) && mc_wr_valid && mc_wr_ready;
  assign push      = cmd_hs && !cmd_is_wr;
  assign pop       = mc_rd_valid && mc_rd_ready && mc_rd_last;
  assign head      = rid_mem[rid_rp];
  assign busy      = (state_q != IDLE) || !rid_empty;
  assign rd_data   = mc_rd_data;
  assign rd_last   = mc_rd_last;

  // round-robin pick: first valid requester after the last one served
  always_comb begin
    int idx;
    logic [GW-1:0] cand;
    nxt_gnt   = '0;
    gnt_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(rr_q) + i) % NUM_REQ;
      cand = GW'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        nxt_gnt   = cand;
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (calib_done && gnt_found) state_d = CMD;
      CMD:     if (cmd_hs) state_d = cmd_is_wr ? WDATA : IDLE;
      WDATA:   if (wr_hs && beat_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // command / write-data outputs, steered from the granted requester
  always_comb begin
    req_ready    = '0;
    wr_ready     = '0;
    mc_cmd_valid = 1'b0;
    mc_cmd_write = 1'b0;
    mc_cmd_addr  = '0;
    mc_cmd_len   = '0;
    mc_wr_valid  = 1'b0;
    mc_wr_data   = '0;
    mc_wr_last   = 1'b0;
    case (state_q)
      CMD: begin
        mc_cmd_valid        = req_valid[grant_id] && !cmd_blk;
        mc_cmd_write        = cmd_is_wr;
        mc_cmd_addr         = addr_a[grant_id];
        mc_cmd_len          = len_a[grant_id];
        req_ready[grant_id] = mc_cmd_ready && !cmd_blk;
      end
      WDATA: begin
        mc_wr_valid        = wr_valid[grant_id];
        mc_wr_data         = wdat_a[grant_id];
        mc_wr_last         = (beat_q == '0);
        wr_ready[grant_id] = mc_wr_ready;
      end
      default: ;
    endcase
  end

  // read return routing to the oldest outstanding issuer
  always_comb begin
    rd_valid       = '0;
    rd_valid[head] = mc_rd_valid && !rid_empty;
    mc_rd_ready    = rd_ready[head] && !rid_empty;
  end

  // grant, round-robin pointer and write beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      rr_q     <= GW'(NUM_REQ-1);
      beat_q   <= '0;
    end else begin
      if (state_q == IDLE && calib_done && gnt_found) grant_id <= nxt_gnt;
      if (cmd_hs) rr_q <= grant_id;
      if (cmd_hs && cmd_is_wr) beat_q <= len_a[grant_id];
      else if (wr_hs)          beat_q <= beat_q - 1'b1;
    end
  end

  // ID FIFO storage (no reset needed, guarded by the count)
  always_ff @(posedge clk) begin
    if (push) rid_mem[rid_wp] <= grant_id;
  end

  // ID FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rid_wp  <= '0;
      rid_rp  <= '0;
      rid_cnt <= '0;
    end else begin
      if (push) rid_wp <= rid_wp + 1'b1;
      if (pop)  rid_rp <= rid_rp + 1'b1;
      case ({push, pop})
        2'b10:   rid_cnt <= rid_cnt + 1'b1;
        2'b01:   rid_cnt <= rid_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // sticky error: read data arrived with nobody waiting for it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           err <= 1'b0;
    else if (mc_rd_valid && rid_empty) err <= 1'b1;
  end

endmodule

// File: tb/tb_rdm_mem_arbiter.sv
// Directed bench for rdm_mem_arbiter (NUM_REQ=2). Inputs change just after
// the falling edge, outputs are sampled 1ns later, state advances on rising.
module tb_rdm_mem_arbiter;
  localparam int NR = 2, AW = 32, DW = 512, LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            calib_done;
  logic [NR-1:0]   req_valid, req_ready, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]   wr_valid, wr_ready;
  logic [NR*DW-1:0] wr_data;
  logic [NR-1:0]   rd_valid, rd_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_last;
  logic            mc_cmd_valid, mc_cmd_ready, mc_cmd_write;
  logic [AW-1:0]   mc_cmd_addr;
  logic [LW-1:0]   mc_cmd_len;
  logic            mc_wr_valid, mc_wr_ready, mc_wr_last;
  logic [DW-1:0]   mc_wr_data;
  logic            mc_rd_valid, mc_rd_ready, mc_rd_last;
  logic [DW-1:0]   mc_rd_data;
  logic [0:0]      grant_id;
  logic            busy, err;

  int n_vec = 0;
  int n_err = 0;

  rdm_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RID_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_cmd_write(mc_cmd_write),
    .mc_cmd_addr(mc_cmd_addr), .mc_cmd_len(mc_cmd_len),
    .mc_wr_valid(mc_wr_valid), .mc_wr_ready(mc_wr_ready), .mc_wr_data(mc_wr_data),
    .mc_wr_last(mc_wr_last),
    .mc_rd_valid(mc_rd_valid), .mc_rd_ready(mc_rd_ready), .mc_rd_data(mc_rd_data),
    .mc_rd_last(mc_rd_last),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  function automatic logic [1:0] oh(input int i);
    logic [1:0] one;
    one = 2'b01;
    return one << i;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; calib_done = 1'b0;
    req_valid = 2'b11; req_write = '0; req_len = '0;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    wr_valid = '0; wr_data = '0; rd_ready = '0;
    mc_cmd_ready = 1'b0; mc_wr_ready = 1'b0;
    mc_rd_valid = 1'b0; mc_rd_last = 1'b0; mc_rd_data = '0;

    // reset state
    repeat (3) nx();
    #1;
    chk("rst_cmd_valid", mc_cmd_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_valid", mc_wr_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_mc_rd_ready", mc_rd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_grant", grant_id, 0);

    // no calibration: nothing issues
    rst = 1'b0; mc_cmd_ready = 1'b1;
    seen = 0;
    repeat (100) begin
      nx(); #1;
      if (mc_cmd_valid || req_ready != 0 || busy) seen++;
    end
    chk("nocalib_activity", seen, 0);

    // alternating reads once calibrated
    calib_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      chk("rr_cmd_valid", mc_cmd_valid, 1);
      chk("rr_grant", grant_id, k % 2);
      chk("rr_addr", mc_cmd_addr, (k % 2) ? 32'h2000 : 32'h1000);
      chk("rr_req_ready", req_ready, oh(k % 2));
      nx(); #1;
      chk("rr_idle", mc_cmd_valid, 0);
      if (k == 3) req_valid = 2'b00;
    end
    chk("rr_busy", busy, 1);

    // return backpressure: head (req0) not ready
    mc_rd_valid = 1'b1; mc_rd_last = 1'b1; rd_ready = 2'b10;
    #1;
    chk("bp_mc_rd_ready", mc_rd_ready, 0);
    chk("bp_rd_valid", rd_valid, 2'b01);
    nx();
    rd_ready = 2'b11;
    for (int e = 0; e < 4; e++) begin
      mc_rd_data = '0; mc_rd_data[15:0] = 16'(e + 5);
      #1;
      chk("ret4_rd_valid", rd_valid, oh(e % 2));
      chk("ret4_mc_rd_ready", mc_rd_ready, 1);
      chk("ret4_rd_data", rd_data[63:0], e + 5);
      nx();
    end
    mc_rd_valid = 1'b0;
    #1;
    chk("ret4_busy", busy, 0);
    chk("ret4_err", err, 0);

    // write burst len=3 from req0 while req1 wants a read
    req_valid = 2'b11; req_write = 2'b01; req_len = {8'd0, 8'd3};
    wr_valid = 2'b01; mc_wr_ready = 1'b1;
    nx(); #1;
    chk("wr_cmd_valid", mc_cmd_valid, 1);
    chk("wr_cmd_grant", grant_id, 0);
    chk("wr_cmd_write", mc_cmd_write, 1);
    chk("wr_cmd_len", mc_cmd_len, 3);
    nx();
    req_valid = 2'b10; req_write = 2'b00;
    for (int b = 0; b < 4; b++) begin
      wr_data[63:0] = 64'(100 + b);
      #1;
      chk("wr_beat_valid", mc_wr_valid, 1);
      chk("wr_beat_ready", wr_ready, 2'b01);
      chk("wr_beat_last", mc_wr_last, b == 3);
      chk("wr_beat_data", mc_wr_data[63:0], 100 + b);
      chk("wr_beat_no_cmd", mc_cmd_valid, 0);
      nx();
    end
    #1;
    chk("wr_done_wr_valid", mc_wr_valid, 0);
    chk("wr_done_cmd_valid", mc_cmd_valid, 0);
    wr_valid = '0;
    nx(); #1;
    chk("wr_then_rd_valid", mc_cmd_valid, 1);
    chk("wr_then_rd_grant", grant_id, 1);
    chk("wr_then_rd_write", mc_cmd_write, 0);
    nx();
    req_valid = 2'b00;
    mc_rd_valid = 1'b1; mc_rd_last = 1'b1;
    #1;
    chk("wr_then_rd_route", rd_valid, 2'b10);
    nx();
    mc_rd_valid = 1'b0;

    // fill the ID FIFO with 8 reads, 9th blocks
    req_valid = 2'b11; req_write = 2'b00; req_len = {8'd1, 8'd1};
    for (int k = 0; k < 8; k++) begin
      nx(); #1;
      chk("fill_cmd_valid", mc_cmd_valid, 1);
      chk("fill_grant", grant_id, k % 2);
      nx();
    end
    nx(); #1;
    chk("full_cmd_valid", mc_cmd_valid, 0);
    chk("full_req_ready", req_ready, 0);
    chk("full_grant", grant_id, 0);
    chk("full_busy", busy, 1);
    nx(); #1;
    chk("full_cmd_held", mc_cmd_valid, 0);
    mc_cmd_ready = 1'b0;
    for (int e = 0; e < 8; e++) begin
      for (int b = 0; b < 2; b++) begin
        mc_rd_valid = 1'b1; mc_rd_last = (b == 1);
        #1;
        chk("drain_rd_valid", rd_valid, oh(e % 2));
        chk("drain_rd_last", rd_last, b == 1);
        nx();
      end
    end
    mc_rd_valid = 1'b0; mc_rd_last = 1'b0;
    #1;
    chk("unblock_cmd_valid", mc_cmd_valid, 1);
    mc_cmd_ready = 1'b1;
    nx();
    req_valid = 2'b00;
    #1;
    chk("ninth_issued", mc_cmd_valid, 0);
    mc_rd_valid = 1'b1; mc_rd_last = 1'b1;
    #1;
    chk("ninth_route", rd_valid, 2'b01);
    nx();
    mc_rd_valid = 1'b0;
    #1;
    chk("drain_busy", busy, 0);

    // stray read data with nothing outstanding
    mc_rd_valid = 1'b1; mc_rd_last = 1'b1;
    #1;
    chk("stray_mc_rd_ready", mc_rd_ready, 0);
    chk("stray_rd_valid", rd_valid, 0);
    nx(); #1;
    chk("stray_err_set", err, 1);
    mc_rd_valid = 1'b0;
    repeat (3) nx();
    #1;
    chk("stray_err_sticky", err, 1);

    // reset in the middle of a write burst, with a read outstanding
    req_valid = 2'b10; req_write = 2'b00;
    nx(); #1;
    chk("r6_rd_grant", grant_id, 1);
    nx();
    req_valid = 2'b01; req_write = 2'b01; req_len = {8'd0, 8'd3}; wr_valid = 2'b01;
    nx(); #1;
    chk("r6_wr_grant", grant_id, 0);
    nx();
    req_valid = 2'b00;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("r6_beat_valid", mc_wr_valid, 1);
      nx();
    end
    #1;
    chk("r6_mid_valid", mc_wr_valid, 1);
    chk("r6_mid_last", mc_wr_last, 0);
    rst = 1'b1;
    #1;
    chk("r6_rst_wr_valid", mc_wr_valid, 0);
    chk("r6_rst_wr_ready", wr_ready, 0);
    chk("r6_rst_busy", busy, 0);
    chk("r6_rst_err", err, 0);
    chk("r6_rst_grant", grant_id, 0);
    nx();
    rst = 1'b0; wr_valid = '0; req_valid = 2'b11; req_write = 2'b00;
    nx(); #1;
    chk("r6_post_cmd_valid", mc_cmd_valid, 1);
    chk("r6_post_grant", grant_id, 0);
    chk("r6_post_req_ready", req_ready, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
